// File: rtl/multiport_rename_regfile_if.sv
// ---------------------------------------------------------------------------
// multiport_rename_regfile_if
//
// Bundles the decoder read ports, the RoB issue (tag allocation) port, the
// RoB commit ports, flush and the busy-register count of the rename register
// file into one interface.
//
// Signals (flattened vectors, port k/j at [k*W +: W]):
//   rd_id     NUM_RD*REG_AW   read register indices        (master -> slave)
//   rd_val    NUM_RD*XLEN     read values                  (slave -> master)
//   rd_busy   NUM_RD          operand still pending        (slave -> master)
//   rd_tag    NUM_RD*ROB_AW   producing RoB tag            (slave -> master)
//   flush     1               misprediction clear          (master -> slave)
//   iss_valid 1               issue allocates destination  (master -> slave)
//   iss_rd    REG_AW          issue destination register   (master -> slave)
//   iss_tag   ROB_AW          issue RoB tag                (master -> slave)
//   cm_valid  NUM_CM          commit strobes               (master -> slave)
//   cm_rd     NUM_CM*REG_AW   commit destinations          (master -> slave)
//   cm_val    NUM_CM*XLEN     commit values                (master -> slave)
//   cm_tag    NUM_CM*ROB_AW   committing RoB tags          (master -> slave)
//   busy_cnt  REG_AW+1        registered busy population   (slave -> master)
// ---------------------------------------------------------------------------
interface multiport_rename_regfile_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int ROB_AW = 4,
  parameter int NUM_RD = 2,
  parameter int NUM_CM = 2
) ();
  logic [NUM_RD*REG_AW-1:0] rd_id;
  logic [NUM_RD*XLEN-1:0]   rd_val;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_RD*ROB_AW-1:0] rd_tag;
  logic                     flush;
  logic                     iss_valid;
  logic [REG_AW-1:0]        iss_rd;
  logic [ROB_AW-1:0]        iss_tag;
  logic [NUM_CM-1:0]        cm_valid;
  logic [NUM_CM*REG_AW-1:0] cm_rd;
  logic [NUM_CM*XLEN-1:0]   cm_val;
  logic [NUM_CM*ROB_AW-1:0] cm_tag;
  logic [REG_AW:0]          busy_cnt;

  modport master (
    output rd_id, flush, iss_valid, iss_rd, iss_tag,
           cm_valid, cm_rd, cm_val, cm_tag,
    input  rd_val, rd_busy, rd_tag, busy_cnt
  );

  modport slave (
    input  rd_id, flush, iss_valid, iss_rd, iss_tag,
           cm_valid, cm_rd, cm_val, cm_tag,
    output rd_val, rd_busy, rd_tag, busy_cnt
  );
endinterface

// File: rtl/multiport_rename_regfile.sv
// ---------------------------------------------------------------------------
// multiport_rename_regfile
//
// Architectural register file plus rename/dependency table. Each register
// carries data, a busy bit and the RoB tag of its pending producer. Reads are
// combinational with issue-match and commit-to-read forwarding; issue, commit
// and flush update state on the rising clock edge when rdy_in is high.
//
// Ports:
//   clk_in   clock
//   rst_in   synchronous active-high reset (priority over rdy_in)
//   rdy_in   global enable; state holds when low
//   bus      multiport_rename_regfile_if.slave (read, issue, commit, flush,
//            busy_cnt)
// ---------------------------------------------------------------------------
module multiport_rename_regfile #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int ROB_AW = 4,
  parameter int NUM_RD = 2,
  parameter int NUM_CM = 2
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  multiport_rename_regfile_if.slave   bus
);
  localparam int NREG = 2 ** REG_AW;

  logic [XLEN-1:0]   data_q [NREG];
  logic [XLEN-1:0]   data_n [NREG];
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_n;
  logic [ROB_AW-1:0] tag_q  [NREG];
  logic [ROB_AW-1:0] tag_n  [NREG];
  logic [REG_AW:0]   busy_cnt_q;
  logic [REG_AW:0]   busy_cnt_n;

  logic [REG_AW-1:0] cm_rd_a  [NUM_CM];
  logic [XLEN-1:0]   cm_val_a [NUM_CM];
  logic [ROB_AW-1:0] cm_tag_a [NUM_CM];
  logic              issue_ok;

  for (genvar j = 0; j < NUM_CM; j++) begin : g_cm
    assign cm_rd_a[j]  = bus.cm_rd[j*REG_AW +: REG_AW];
    assign cm_val_a[j] = bus.cm_val[j*XLEN +: XLEN];
    assign cm_tag_a[j] = bus.cm_tag[j*ROB_AW +: ROB_AW];
  end

  assign issue_ok = bus.iss_valid && (bus.iss_rd != '0);

  // Read ports. Later commit ports override earlier ones so the youngest
  // matching commit forwards; an issue match overrides everything because
  // the reader must wait for the newly allocated producer.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [REG_AW-1:0] id;
    logic [XLEN-1:0]   val;
    logic              busy;
    logic [ROB_AW-1:0] tag;

    assign id = bus.rd_id[k*REG_AW +: REG_AW];

    always_comb begin
      val  = data_q[id];
      busy = busy_q[id];
      tag  = tag_q[id];
      for (int j = 0; j < NUM_CM; j++) begin
        if (bus.cm_valid[j] && (cm_rd_a[j] == id) &&
            (cm_tag_a[j] == tag_q[id]) && busy_q[id]) begin
          val  = cm_val_a[j];
          busy = 1'b0;
          tag  = '0;
        end
      end
      if (issue_ok && (bus.iss_rd == id)) begin
        val  = data_q[id];
        busy = 1'b1;
        tag  = bus.iss_tag;
      end
    end

    assign bus.rd_val[k*XLEN +: XLEN]     = val;
    assign bus.rd_busy[k]                 = busy;
    assign bus.rd_tag[k*ROB_AW +: ROB_AW] = tag;
  end

  // Next-state computation. Data writes ignore flush so retired results are
  // never lost. Commit clears compare against the pre-update tag, so a stale
  // commit (younger rename present) leaves the register busy. The issue is
  // applied last and excluded from the clear, giving it priority.
  always_comb begin
    data_n     = data_q;
    busy_n     = busy_q;
    tag_n      = tag_q;
    busy_cnt_n = '0;

    for (int j = 0; j < NUM_CM; j++) begin
      if (bus.cm_valid[j] && (cm_rd_a[j] != '0)) begin
        data_n[cm_rd_a[j]] = cm_val_a[j];
      end
    end

    if (bus.flush) begin
      busy_n = '0;
      for (int i = 0; i < NREG; i++) begin
        tag_n[i] = '0;
      end
    end else begin
      for (int j = 0; j < NUM_CM; j++) begin
        if (bus.cm_valid[j] && (cm_rd_a[j] != '0) &&
            (tag_q[cm_rd_a[j]] == cm_tag_a[j]) &&
            !(issue_ok && (bus.iss_rd == cm_rd_a[j]))) begin
          busy_n[cm_rd_a[j]] = 1'b0;
          tag_n[cm_rd_a[j]]  = '0;
        end
      end
      if (issue_ok) begin
        busy_n[bus.iss_rd] = 1'b1;
        tag_n[bus.iss_rd]  = bus.iss_tag;
      end
    end

    for (int i = 0; i < NREG; i++) begin
      busy_cnt_n = busy_cnt_n + {{REG_AW{1'b0}}, busy_n[i]};
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NREG; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < NREG; i++) begin
        data_q[i] <= data_n[i];
        tag_q[i]  <= tag_n[i];
      end
      busy_q     <= busy_n;
      busy_cnt_q <= busy_cnt_n;
    end
  end

  assign bus.busy_cnt = busy_cnt_q;

endmodule
